// File: rtl/bomb_pkg.sv
// Shared cell/wall codes, state encodings and direction helpers for the bomb engine.
package bomb_pkg;

    localparam logic [2:0] CELL_EMPTY     = 3'd0;
    localparam logic [2:0] CELL_READY_EXP = 3'd1;
    localparam logic [2:0] CELL_BOMB_UN   = 3'd2;
    localparam logic [2:0] CELL_UP        = 3'd3;
    localparam logic [2:0] CELL_DOWN      = 3'd4;
    localparam logic [2:0] CELL_LEFT      = 3'd5;
    localparam logic [2:0] CELL_RIGHT     = 3'd6;
    localparam logic [2:0] CELL_CEN       = 3'd7;

    localparam logic [1:0] WALL_EMPTY = 2'd0;
    localparam logic [1:0] WALL_SOFT  = 2'd1;
    localparam logic [1:0] WALL_HARD  = 2'd2;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_PENDING, S_PAINT, S_BURN, S_CLEARQ, S_CLEAR
    } slot_state_t;

    typedef enum logic [2:0] {
        P_IDLE, P_CEN, P_ARM, P_NEXTDIR, P_CLR_CEN, P_CLR_ARM
    } painter_state_t;

    // Offsets are mod-256 cell index deltas: -16, +16, -1, +1.
    function automatic logic [7:0] dir_offset(input logic [1:0] dir);
        case (dir)
            DIR_UP:   return 8'hF0;
            DIR_DOWN: return 8'h10;
            DIR_LEFT: return 8'hFF;
            default:  return 8'h01;
        endcase
    endfunction

    function automatic logic [2:0] dir_code(input logic [1:0] dir);
        case (dir)
            DIR_UP:   return CELL_UP;
            DIR_DOWN: return CELL_DOWN;
            DIR_LEFT: return CELL_LEFT;
            default:  return CELL_RIGHT;
        endcase
    endfunction

endpackage

// File: rtl/bomb_arm_walker.sv
// Combinational arm step: cell index reached from pos after step cells in dir, plus edge detect.
module bomb_arm_walker
    import bomb_pkg::*;
(
    input  logic [7:0] i_pos,
    input  logic [1:0] i_dir,
    input  logic [2:0] i_step,
    output logic [7:0] o_idx,
    output logic       o_off_grid
);

    logic [4:0] w_row;
    logic [4:0] w_col;
    logic [4:0] w_step;

    assign w_row  = {1'b0, i_pos[7:4]};
    assign w_col  = {1'b0, i_pos[3:0]};
    assign w_step = {2'b00, i_step};
    assign o_idx  = i_pos + ({5'd0, i_step} * dir_offset(i_dir));

    always_comb begin
        o_off_grid = 1'b0;
        unique case (i_dir)
            DIR_UP:    o_off_grid = (w_step > w_row);
            DIR_DOWN:  o_off_grid = ((w_row + w_step) > 5'd15);
            DIR_LEFT:  o_off_grid = (w_step > w_col);
            DIR_RIGHT: o_off_grid = ((w_col + w_step) > 5'd15);
        endcase
    end

endmodule

// File: rtl/bomb_engine.sv
// Bomb slot manager and single explosion painter driving the 256-cell bomb grid.
module bomb_engine
    import bomb_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned FUSE_TICKS = 3,
    parameter int unsigned BURN_TICKS = 2,
    parameter int unsigned MAX_LEN    = 7
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_tick,
    input  logic              i_place_req,
    input  logic [7:0]        i_place_pos,
    input  logic [2:0]        i_place_len,
    output logic              o_place_ack,
    output logic              o_place_rej,
    input  logic [255:0][1:0] i_wall_grid,
    output logic [255:0][2:0] o_bomb_grid,
    output logic              o_wall_break_vld,
    output logic [7:0]        o_wall_break_pos,
    output logic              o_bomb_done,
    output logic              o_busy
);

    localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    slot_state_t       r_state [NUM_SLOTS];
    logic [7:0]        r_pos   [NUM_SLOTS];
    logic [2:0]        r_len   [NUM_SLOTS];
    logic [7:0]        r_fuse  [NUM_SLOTS];
    logic [7:0]        r_burn  [NUM_SLOTS];
    logic [3:0][2:0]   r_reach [NUM_SLOTS];
    logic [255:0][2:0] r_grid;

    painter_state_t r_pstate, w_pstate_d;
    logic [SW-1:0]  r_pslot, w_pslot_d;
    logic [1:0]     r_dir, w_dir_d;
    logic [2:0]     r_step, w_step_d;

    logic       r_ack, r_rej, r_wb_vld, r_done;
    logic [7:0] r_wb_pos;

    logic           w_free_found, w_clr_found, w_pen_found, w_place_ok;
    logic [SW-1:0]  w_free_idx, w_clr_idx, w_pen_idx;
    logic [2:0]     w_place_len;
    logic [7:0]     w_cur_pos, w_walk_idx, w_wr_idx;
    logic [2:0]     w_cur_len, w_cur_reach, w_wr_code, w_reach_val;
    logic           w_off, w_wr_en, w_wb_vld, w_reach_we;
    logic           w_start_paint, w_start_clear, w_end_paint, w_end_clear;
    logic [NUM_SLOTS-1:0] w_chain;

    assign w_cur_pos   = r_pos[r_pslot];
    assign w_cur_len   = r_len[r_pslot];
    assign w_cur_reach = r_reach[r_pslot][r_dir];

    bomb_arm_walker u_walker (
        .i_pos      (w_cur_pos),
        .i_dir      (r_dir),
        .i_step     (r_step),
        .o_idx      (w_walk_idx),
        .o_off_grid (w_off)
    );

    // Descending scan so the lowest matching slot index wins.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_clr_found  = 1'b0;
        w_clr_idx    = '0;
        w_pen_found  = 1'b0;
        w_pen_idx    = '0;
        for (int s = int'(NUM_SLOTS) - 1; s >= 0; s--) begin
            if (r_state[s] == S_IDLE) begin
                w_free_found = 1'b1;
                w_free_idx   = SW'(s);
            end
            if (r_state[s] == S_CLEARQ) begin
                w_clr_found = 1'b1;
                w_clr_idx   = SW'(s);
            end
            if (r_state[s] == S_PENDING) begin
                w_pen_found = 1'b1;
                w_pen_idx   = SW'(s);
            end
        end
    end

    always_comb begin
        w_place_len = i_place_len;
        if (i_place_len == 3'd0) begin
            w_place_len = 3'd1;
        end else if ({29'd0, i_place_len} > MAX_LEN) begin
            w_place_len = 3'(MAX_LEN);
        end
    end

    assign w_place_ok = w_free_found && (r_grid[i_place_pos] == CELL_EMPTY)
                     && (i_wall_grid[i_place_pos] == WALL_EMPTY)
                     && !(w_wr_en && (w_wr_idx == i_place_pos));

    always_comb begin
        w_pstate_d    = r_pstate;
        w_pslot_d     = r_pslot;
        w_dir_d       = r_dir;
        w_step_d      = r_step;
        w_wr_en       = 1'b0;
        w_wr_idx      = w_walk_idx;
        w_wr_code     = CELL_EMPTY;
        w_wb_vld      = 1'b0;
        w_reach_we    = 1'b0;
        w_reach_val   = '0;
        w_start_paint = 1'b0;
        w_start_clear = 1'b0;
        w_end_paint   = 1'b0;
        w_end_clear   = 1'b0;
        unique case (r_pstate)
            P_IDLE: begin
                if (w_clr_found) begin
                    w_pslot_d     = w_clr_idx;
                    w_pstate_d    = P_CLR_CEN;
                    w_start_clear = 1'b1;
                end else if (w_pen_found) begin
                    w_pslot_d     = w_pen_idx;
                    w_pstate_d    = P_CEN;
                    w_start_paint = 1'b1;
                end
            end
            P_CEN: begin
                w_wr_en    = 1'b1;
                w_wr_idx   = w_cur_pos;
                w_wr_code  = CELL_CEN;
                w_pstate_d = P_ARM;
                w_dir_d    = DIR_UP;
                w_step_d   = 3'd1;
            end
            P_ARM: begin
                w_reach_we = 1'b1;
                if (w_off || (i_wall_grid[w_walk_idx] == WALL_HARD)) begin
                    w_reach_val = r_step - 3'd1;
                    w_pstate_d  = P_NEXTDIR;
                end else begin
                    w_wr_en     = (r_grid[w_walk_idx] != CELL_CEN);
                    w_wr_code   = dir_code(r_dir);
                    w_reach_val = r_step;
                    if (i_wall_grid[w_walk_idx] == WALL_SOFT) begin
                        w_wb_vld   = 1'b1;
                        w_pstate_d = P_NEXTDIR;
                    end else if (r_step >= w_cur_len) begin
                        w_pstate_d = P_NEXTDIR;
                    end else begin
                        w_step_d = r_step + 3'd1;
                    end
                end
            end
            P_NEXTDIR: begin
                if (r_dir == DIR_RIGHT) begin
                    w_end_paint = 1'b1;
                    w_pstate_d  = P_IDLE;
                end else begin
                    w_dir_d    = r_dir + 2'd1;
                    w_step_d   = 3'd1;
                    w_pstate_d = P_ARM;
                end
            end
            P_CLR_CEN: begin
                w_wr_idx   = w_cur_pos;
                w_wr_en    = (r_grid[w_cur_pos] >= CELL_UP);
                w_pstate_d = P_CLR_ARM;
                w_dir_d    = DIR_UP;
                w_step_d   = 3'd1;
            end
            P_CLR_ARM: begin
                // Walls are ignored here; only explosion codes are wiped.
                w_wr_en = (r_step <= w_cur_reach) && (r_grid[w_walk_idx] >= CELL_UP);
                if (r_step >= w_cur_reach) begin
                    if (r_dir == DIR_RIGHT) begin
                        w_end_clear = 1'b1;
                        w_pstate_d  = P_IDLE;
                    end else begin
                        w_dir_d  = r_dir + 2'd1;
                        w_step_d = 3'd1;
                    end
                end else begin
                    w_step_d = r_step + 3'd1;
                end
            end
            default: w_pstate_d = P_IDLE;
        endcase
    end

    always_comb begin
        for (int s = 0; s < int'(NUM_SLOTS); s++) begin
            w_chain[s] = (r_pstate == P_ARM) && w_wr_en && (r_state[s] == S_ARMED)
                      && (r_pos[s] == w_wr_idx);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_grid   <= '0;
            r_pstate <= P_IDLE;
            r_pslot  <= '0;
            r_dir    <= '0;
            r_step   <= '0;
            r_ack    <= 1'b0;
            r_rej    <= 1'b0;
            r_wb_vld <= 1'b0;
            r_wb_pos <= '0;
            r_done   <= 1'b0;
            for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                r_state[s] <= S_IDLE;
                r_pos[s]   <= '0;
                r_len[s]   <= '0;
                r_fuse[s]  <= '0;
                r_burn[s]  <= '0;
                r_reach[s] <= '0;
            end
        end else begin
            r_pstate <= w_pstate_d;
            r_pslot  <= w_pslot_d;
            r_dir    <= w_dir_d;
            r_step   <= w_step_d;
            r_ack    <= i_place_req && w_place_ok;
            r_rej    <= i_place_req && !w_place_ok;
            r_wb_vld <= w_wb_vld;
            r_done   <= 1'b0;
            if (w_wb_vld) r_wb_pos <= w_wr_idx;
            if (w_wr_en) r_grid[w_wr_idx] <= w_wr_code;
            if (w_reach_we) r_reach[r_pslot][r_dir] <= w_reach_val;
            for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                unique case (r_state[s])
                    S_ARMED: begin
                        if (w_chain[s] || (i_tick && (r_fuse[s] <= 8'd1))) begin
                            r_state[s] <= S_PENDING;
                        end else if (i_tick) begin
                            r_fuse[s] <= r_fuse[s] - 8'd1;
                        end
                    end
                    S_PENDING: begin
                        // Later in this block than the painter write, so READY_EXP wins.
                        r_grid[r_pos[s]] <= CELL_READY_EXP;
                        if (w_start_paint && (w_pslot_d == SW'(s))) r_state[s] <= S_PAINT;
                    end
                    S_PAINT: begin
                        if (w_end_paint && (r_pslot == SW'(s))) begin
                            r_state[s] <= S_BURN;
                            r_burn[s]  <= 8'(BURN_TICKS);
                        end
                    end
                    S_BURN: begin
                        if (i_tick) begin
                            r_burn[s] <= r_burn[s] - 8'd1;
                            if (r_burn[s] <= 8'd1) r_state[s] <= S_CLEARQ;
                        end
                    end
                    S_CLEARQ: begin
                        if (w_start_clear && (w_pslot_d == SW'(s))) r_state[s] <= S_CLEAR;
                    end
                    S_CLEAR: begin
                        if (w_end_clear && (r_pslot == SW'(s))) begin
                            r_state[s] <= S_IDLE;
                            r_done     <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (i_place_req && w_place_ok) begin
                r_state[w_free_idx] <= S_ARMED;
                r_pos[w_free_idx]   <= i_place_pos;
                r_len[w_free_idx]   <= w_place_len;
                r_fuse[w_free_idx]  <= 8'(FUSE_TICKS);
                r_grid[i_place_pos] <= CELL_BOMB_UN;
            end
        end
    end

    assign o_bomb_grid      = r_grid;
    assign o_place_ack      = r_ack;
    assign o_place_rej      = r_rej;
    assign o_wall_break_vld = r_wb_vld;
    assign o_wall_break_pos = r_wb_pos;
    assign o_bomb_done      = r_done;
    assign o_busy           = (r_pstate != P_IDLE);

endmodule

// File: tb/tb_bomb_engine.sv
// Directed bench for bomb_engine: placement, painting, walls, chains, capacity and reset.
module tb_bomb_engine;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              tick;
    logic              place_req;
    logic [7:0]        place_pos;
    logic [2:0]        place_len;
    logic              place_ack;
    logic              place_rej;
    logic [255:0][1:0] wall_grid;
    logic [255:0][2:0] bomb_grid;
    logic              wb_vld;
    logic [7:0]        wb_pos;
    logic              bomb_done;
    logic              busy;

    int         checks   = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         wb_cnt   = 0;
    logic [7:0] wb_last  = '0;
    logic       saw57    = 1'b0;

    always #5 clk = ~clk;

    bomb_engine dut (
        .i_clk            (clk),
        .i_reset_n        (reset_n),
        .i_tick           (tick),
        .i_place_req      (place_req),
        .i_place_pos      (place_pos),
        .i_place_len      (place_len),
        .o_place_ack      (place_ack),
        .o_place_rej      (place_rej),
        .i_wall_grid      (wall_grid),
        .o_bomb_grid      (bomb_grid),
        .o_wall_break_vld (wb_vld),
        .o_wall_break_pos (wb_pos),
        .o_bomb_done      (bomb_done),
        .o_busy           (busy)
    );

    always @(negedge clk) begin
        if (bomb_done) done_cnt++;
        if (wb_vld) begin
            wb_cnt++;
            wb_last = wb_pos;
        end
        if (bomb_grid[8'h57] == 3'd1 && busy) saw57 = 1'b1;
    end

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        tick      = 1'b0;
        place_req = 1'b0;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        done_cnt = 0;
        wb_cnt   = 0;
        saw57    = 1'b0;
    endtask

    task automatic place(input logic [7:0] pos, input logic [2:0] len, input logic with_tick);
        place_req = 1'b1;
        place_pos = pos;
        place_len = len;
        tick      = with_tick;
        @(posedge clk);
        #1;
        place_req = 1'b0;
        tick      = 1'b0;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bomb_grid !== '0) begin
            failures++;
            $display("FAIL reset_grid got_nonzero=%0d exp=0", (bomb_grid != '0));
        end
        checks++;
        if ({busy, place_ack, place_rej, wb_vld, bomb_done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outs got=%b exp=00000",
                     {busy, place_ack, place_rej, wb_vld, bomb_done});
        end
    endtask

    task automatic test_basic();
        logic [7:0] cells [10] = '{8'h45, 8'h35, 8'h65, 8'h75, 8'h54, 8'h53, 8'h56, 8'h57,
                                   8'h25, 8'h58};
        logic [2:0] codes [10] = '{3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd0, 3'd0};
        do_reset();
        place(8'h55, 3'd2, 1'b0);
        checks++;
        if ({place_ack, place_rej} !== 2'b10) begin
            failures++;
            $display("FAIL basic_ack got=%b exp=10", {place_ack, place_rej});
        end
        checks++;
        if (bomb_grid[8'h55] !== 3'd2) begin
            failures++;
            $display("FAIL basic_bomb_un got=%0d exp=2", bomb_grid[8'h55]);
        end
        repeat (3) tick_once();
        cycle(1);
        checks++;
        if (bomb_grid[8'h55] !== 3'd1) begin
            failures++;
            $display("FAIL basic_ready got=%0d exp=1", bomb_grid[8'h55]);
        end
        cycle(1);
        checks++;
        if (bomb_grid[8'h55] !== 3'd7 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_cen got=%0d busy=%b exp=7 busy=1", bomb_grid[8'h55], busy);
        end
        cycle(40);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bomb_grid[cells[i]] !== codes[i]) begin
                failures++;
                $display("FAIL basic_paint cell=%h got=%0d exp=%0d",
                         cells[i], bomb_grid[cells[i]], codes[i]);
            end
        end
        checks++;
        if (busy !== 1'b0 || done_cnt != 0) begin
            failures++;
            $display("FAIL basic_burning busy=%b done=%0d exp busy=0 done=0", busy, done_cnt);
        end
        repeat (2) tick_once();
        cycle(40);
        checks++;
        if (bomb_grid !== '0) begin
            failures++;
            $display("FAIL basic_cleared got_nonzero=1 exp=0");
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL basic_done got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_edge();
        logic [7:0] cells [11] = '{8'h10, 8'h20, 8'h30, 8'h01, 8'h02, 8'h03, 8'h00, 8'hF0,
                                   8'h0F, 8'h40, 8'h04};
        logic [2:0] codes [11] = '{3'd4, 3'd4, 3'd4, 3'd6, 3'd6, 3'd6, 3'd7, 3'd0, 3'd0,
                                   3'd0, 3'd0};
        do_reset();
        place(8'h00, 3'd3, 1'b0);
        repeat (3) tick_once();
        cycle(45);
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (bomb_grid[cells[i]] !== codes[i]) begin
                failures++;
                $display("FAIL edge_paint cell=%h got=%0d exp=%0d",
                         cells[i], bomb_grid[cells[i]], codes[i]);
            end
        end
    endtask

    task automatic test_walls();
        logic [7:0] cells [13] = '{8'h57, 8'h56, 8'h58, 8'h45, 8'h35, 8'h65, 8'h75, 8'h85,
                                   8'h54, 8'h53, 8'h52, 8'h55, 8'h25};
        logic [2:0] codes [13] = '{3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 3'd4, 3'd4, 3'd4, 3'd5,
                                   3'd5, 3'd5, 3'd7, 3'd0};
        wall_grid[8'h57] = 2'd1;
        wall_grid[8'h45] = 2'd2;
        do_reset();
        place(8'h55, 3'd3, 1'b0);
        repeat (3) tick_once();
        cycle(45);
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (bomb_grid[cells[i]] !== codes[i]) begin
                failures++;
                $display("FAIL walls_paint cell=%h got=%0d exp=%0d",
                         cells[i], bomb_grid[cells[i]], codes[i]);
            end
        end
        checks++;
        if (wb_cnt != 1 || wb_last !== 8'h57) begin
            failures++;
            $display("FAIL walls_break count=%0d pos=%h exp count=1 pos=57", wb_cnt, wb_last);
        end
        wall_grid = '0;
    endtask

    task automatic test_chain();
        logic [7:0] cells [8] = '{8'h57, 8'h58, 8'h56, 8'h47, 8'h67, 8'h55, 8'h45, 8'h75};
        logic [2:0] codes [8] = '{3'd7, 3'd6, 3'd5, 3'd3, 3'd4, 3'd7, 3'd3, 3'd4};
        do_reset();
        place(8'h55, 3'd2, 1'b0);
        tick_once();
        place(8'h57, 3'd1, 1'b0);
        checks++;
        if (place_ack !== 1'b1) begin
            failures++;
            $display("FAIL chain_place_b got=%b exp=1", place_ack);
        end
        repeat (2) tick_once();
        cycle(60);
        checks++;
        if (saw57 !== 1'b1) begin
            failures++;
            $display("FAIL chain_ready got=%b exp=1", saw57);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bomb_grid[cells[i]] !== codes[i]) begin
                failures++;
                $display("FAIL chain_paint cell=%h got=%0d exp=%0d",
                         cells[i], bomb_grid[cells[i]], codes[i]);
            end
        end
    endtask

    task automatic test_capacity();
        logic [7:0] more [3] = '{8'h22, 8'h33, 8'h44};
        do_reset();
        place(8'h11, 3'd1, 1'b0);
        place(8'h11, 3'd1, 1'b0);
        checks++;
        if ({place_ack, place_rej} !== 2'b01) begin
            failures++;
            $display("FAIL cap_occupied got=%b exp=01", {place_ack, place_rej});
        end
        for (int i = 0; i < 3; i++) begin
            place(more[i], 3'd1, 1'b0);
            checks++;
            if ({place_ack, place_rej} !== 2'b10) begin
                failures++;
                $display("FAIL cap_accept pos=%h got=%b exp=10", more[i], {place_ack, place_rej});
            end
        end
        place(8'h66, 3'd1, 1'b0);
        checks++;
        if ({place_ack, place_rej} !== 2'b01 || bomb_grid[8'h66] !== 3'd0) begin
            failures++;
            $display("FAIL cap_full got=%b cell=%0d exp=01 cell=0",
                     {place_ack, place_rej}, bomb_grid[8'h66]);
        end
    endtask

    task automatic test_len0_tick();
        logic [7:0] cells [8] = '{8'h78, 8'h68, 8'h98, 8'hA8, 8'h87, 8'h86, 8'h89, 8'h8A};
        logic [2:0] codes [8] = '{3'd3, 3'd0, 3'd4, 3'd0, 3'd5, 3'd0, 3'd6, 3'd0};
        do_reset();
        place(8'h88, 3'd0, 1'b1);
        repeat (2) tick_once();
        cycle(3);
        checks++;
        if (bomb_grid[8'h88] !== 3'd2) begin
            failures++;
            $display("FAIL len0_fuse_hold got=%0d exp=2", bomb_grid[8'h88]);
        end
        tick_once();
        cycle(1);
        checks++;
        if (bomb_grid[8'h88] !== 3'd1) begin
            failures++;
            $display("FAIL len0_ready got=%0d exp=1", bomb_grid[8'h88]);
        end
        cycle(30);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bomb_grid[cells[i]] !== codes[i]) begin
                failures++;
                $display("FAIL len0_paint cell=%h got=%0d exp=%0d",
                         cells[i], bomb_grid[cells[i]], codes[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        place(8'h55, 3'd2, 1'b0);
        repeat (3) tick_once();
        cycle(6);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_busy_before got=%b exp=1", busy);
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bomb_grid !== '0) begin
            failures++;
            $display("FAIL midrst_grid got_nonzero=1 exp=0");
        end
        checks++;
        if ({busy, place_ack, place_rej, wb_vld, bomb_done} !== 5'b0) begin
            failures++;
            $display("FAIL midrst_outs got=%b exp=00000",
                     {busy, place_ack, place_rej, wb_vld, bomb_done});
        end
        reset_n = 1'b1;
        place(8'h55, 3'd2, 1'b0);
        cycle(5);
        checks++;
        if (place_rej !== 1'b0 || busy !== 1'b0 || bomb_grid[8'h55] !== 3'd2) begin
            failures++;
            $display("FAIL midrst_after rej=%b busy=%b cell=%0d exp rej=0 busy=0 cell=2",
                     place_rej, busy, bomb_grid[8'h55]);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        tick      = 1'b0;
        place_req = 1'b0;
        place_pos = '0;
        place_len = '0;
        wall_grid = '0;
        test_reset();
        test_basic();
        test_edge();
        test_walls();
        test_chain();
        test_capacity();
        test_len0_tick();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
